// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost flags,
// sticky overflow/underflow errors and selectable standard or FWFT read port.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wrt_data,
  input  logic                  wrt_en,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;

  // Acceptance uses the registered (pre-edge) flags, so a full FIFO never writes
  // through even when a read frees a slot in the same cycle.
  assign wr_acc = wrt_en && !full_q;
  assign rd_acc = rd_en && !empty_q;
  assign waddr  = wptr_q[ADDR_WIDTH-1:0];
  assign raddr  = rptr_q[ADDR_WIDTH-1:0];

  // NOTE: every variable gets a default at the top of always_comb, so no latch can be inferred.
  always_comb begin
    wptr_d      = wptr_q + PW'(wr_acc);
    rptr_d      = rptr_q + PW'(rd_acc);
    count_d     = count_q + PW'(wr_acc) - PW'(rd_acc);
    full_d      = (count_d == PW'(DEPTH));
    empty_d     = (count_d == '0);
    af_d        = (count_d >= PW'(AF_THRESH));
    ae_d        = (count_d <= PW'(AE_THRESH));
    overflow_d  = (overflow_q  && !clr_err) || (wrt_en && full_q);
    underflow_d = (underflow_q && !clr_err) || (rd_en && empty_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage has no reset; stale contents are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[waddr] <= wrt_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; forced to zero while empty so
      // reset and idle show a clean bus.
      assign rd_data  = empty_q ? '0 : mem[raddr];
      assign rd_valid = !empty_q;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
      logic                  rd_valid_q, rd_valid_d;

      always_comb begin
        rd_data_d  = rd_acc ? mem[raddr] : rd_data_q;
        rd_valid_d = rd_acc;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and
// compares both against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] wrt_data = '0;
  logic          wrt_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;

  logic [DW-1:0] s_rd_data, f_rd_data;
  logic          s_rd_valid, f_rd_valid;
  logic          s_full, f_full, s_empty, f_empty;
  logic          s_af, f_af, s_ae, f_ae;
  logic [AW:0]   s_count, f_count;
  logic          s_ovf, f_ovf, s_unf, f_unf;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic          m_ovf, m_unf;
  logic [DW-1:0] m_rd_data;
  logic          m_rd_valid;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wrt_data(wrt_data), .wrt_en(wrt_en), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wrt_data(wrt_data), .wrt_en(wrt_en), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf      = 1'b0;
    m_unf      = 1'b0;
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
  endtask

  // One edge of the FIFO described by its rules, using pre-edge occupancy.
  task automatic model_step(input logic we, input logic re, input logic ce, input logic [DW-1:0] d);
    int  n;
    bit  was_full, was_empty;
    n         = mq.size();
    was_full  = (n == DEPTH);
    was_empty = (n == 0);
    m_rd_valid = 1'b0;
    if (re && !was_empty) begin
      m_rd_data  = mq.pop_front();
      m_rd_valid = 1'b1;
    end
    if (we && !was_full) mq.push_back(d);
    m_ovf = (m_ovf && !ce) || (we && was_full);
    m_unf = (m_unf && !ce) || (re && was_empty);
  endtask

  task automatic compare_all();
    int n;
    logic [DW-1:0] head;
    n    = mq.size();
    head = (n > 0) ? mq[0] : '0;
    check("s_count", 32'(s_count), 32'(n));
    check("f_count", 32'(f_count), 32'(n));
    check("s_full", 32'(s_full), 32'(n == DEPTH));
    check("f_full", 32'(f_full), 32'(n == DEPTH));
    check("s_empty", 32'(s_empty), 32'(n == 0));
    check("f_empty", 32'(f_empty), 32'(n == 0));
    check("s_almost_full", 32'(s_af), 32'(n >= AF));
    check("f_almost_full", 32'(f_af), 32'(n >= AF));
    check("s_almost_empty", 32'(s_ae), 32'(n <= AE));
    check("f_almost_empty", 32'(f_ae), 32'(n <= AE));
    check("s_overflow", 32'(s_ovf), 32'(m_ovf));
    check("f_overflow", 32'(f_ovf), 32'(m_ovf));
    check("s_underflow", 32'(s_unf), 32'(m_unf));
    check("f_underflow", 32'(f_unf), 32'(m_unf));
    check("s_rd_valid", 32'(s_rd_valid), 32'(m_rd_valid));
    check("s_rd_data", 32'(s_rd_data), 32'(m_rd_data));
    check("f_rd_valid", 32'(f_rd_valid), 32'(n > 0));
    check("f_rd_data", 32'(f_rd_data), 32'(head));
  endtask

  task automatic cycle(input logic we, input logic re, input logic ce, input logic [DW-1:0] d);
    @(negedge clk);
    wrt_en   = we;
    rd_en    = re;
    clr_err  = ce;
    wrt_data = d;
    @(posedge clk);
    model_step(we, re, ce, d);
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    // Reset held for 5 cycles, checked before and after release
    repeat (5) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, '0);

    // Fill with 1..16, then one rejected write of 99
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0, 1'b0, DW'(i));
      if (i == AF) check("af_at_14", 32'(s_af), 32'd1);
    end
    check("full_at_16", 32'(s_full), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, DW'(99));
    check("ovf_17th", 32'(s_ovf), 32'd1);
    check("count_stays_16", 32'(s_count), 32'd16);

    // Drain 17 reads in standard mode
    for (int i = 1; i <= DEPTH + 1; i++) begin
      cycle(1'b0, 1'b1, 1'b0, '0);
      if (i <= DEPTH) check("drain_data", 32'(s_rd_data), 32'(i));
    end
    check("unf_17th", 32'(s_unf), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, '0);
    check("clr_ovf", 32'(s_ovf), 32'd0);
    check("clr_unf", 32'(s_unf), 32'd0);

    // Streaming with simultaneous read and write across many wraps
    for (int i = 1; i <= 206; i++) begin
      cycle(1'b1, 1'b1, 1'b0, DW'(i));
      if (i >= 2) check("stream_data", 32'(s_rd_data), 32'(i - 1));
    end
    cycle(1'b0, 1'b1, 1'b1, '0);

    // FWFT: word visible before any rd_en, then popped
    cycle(1'b1, 1'b0, 1'b0, 16'hABCD);
    check("fwft_data", 32'(f_rd_data), 32'h0000ABCD);
    check("fwft_valid", 32'(f_rd_valid), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("fwft_empty", 32'(f_empty), 32'd1);
    check("fwft_valid_low", 32'(f_rd_valid), 32'd0);

    // Randomized traffic, clr_err rare
    for (int i = 0; i < 1500; i++) begin
      logic we, re, ce;
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 50);
      ce = ($urandom_range(0, 99) < 5);
      cycle(we, re, ce, DW'($urandom));
    end

    // Mid-operation asynchronous reset
    cycle(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, DW'($urandom));
    @(negedge clk);
    wrt_en = 1'b0;
    rd_en  = 1'b0;
    clr_err = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("async_count", 32'(s_count), 32'd0);
    check("async_f_rd_data", 32'(f_rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("post_reset_unf", 32'(s_unf), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
